count_session_arbiter: RTL and testbench
========================================

// Module: count_session_arbiter
// PURPOSE
//  Shares one W-bit event counter between N requesters. Each requester asks for a counting
//  session with its own target. The block grants requesters round-robin, counts x pulses for
//  the granted session until cnt equals the target, then pulses that requester's done bit.
//  It is the sequencing/arbitration layer above the counter-plus-controller datapath.
// PARAMETERS
//  N  4  number of requesters (>=2)
//  W  4  counter/target width; max target 2**W-1
// PORTS
//  clk     in   1    clock; all state changes on posedge
//  reset   in   1    synchronous, active-low reset
//  req     in   N    session request, one bit per requester; level, held until done or abort
//  target  in   N*W  packed targets; requester i uses target[i*W +: W]
//  x       in   1    event strobe; counted only while in COUNT
//  gnt     out  N    one-hot grant, registered
//  busy    out  1    1 in COUNT or DONE
//  cnt     out  W    current session count, registered
//  done    out  N    one-cycle completion pulse to the granted requester
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, gnt=0, cnt=0, done=0, busy=0, rr_ptr=0,
//    tgt_r=0. Reset mid-session drops the session; no done pulse is issued.
//  - States (2-bit): IDLE, COUNT, DONE.
//  - IDLE: if req!=0, pick the first set req at or after rr_ptr, wrapping modulo N.
//    Next edge: gnt<=onehot(sel), owner<=sel, tgt_r<=target[sel], cnt<=0, ->COUNT.
//    If req==0, stay in IDLE. Grant latency: req seen at edge k -> gnt high after edge k.
//  - COUNT (evaluated each edge, priority order):
//    1) req[owner]==0 (abort): ->IDLE, gnt<=0, cnt holds, rr_ptr<=owner+1, no done.
//    2) cnt==tgt_r: ->DONE; no increment, even if x==1.
//    3) x==1: cnt<=cnt+1.
//    4) otherwise cnt holds.
//  - DONE: lasts exactly one cycle. done = gnt & {N{state==DONE}} (one-hot, one cycle).
//    Next edge: ->IDLE, gnt<=0, rr_ptr<=owner+1 mod N; cnt keeps its final value until next grant.
//  - target is sampled only at grant; later changes to target are ignored.
//  - target==0: one COUNT cycle, then DONE. Total from grant to done = tgt+1 cycles, plus one
//    cycle per cycle with x==0.
//  - cnt never exceeds tgt_r <= 2**W-1, so no wrap occurs.
//  - Fairness: the owner gets lowest priority in the next arbitration. A req still high in
//    IDLE after done is a new request.
//  - req bits of non-owners are ignored while busy.
//  - busy = (state!=IDLE); gnt==0 exactly when state==IDLE.
// STRUCTURE
//  - Shared package: state encoding localparams (S_IDLE=0, S_COUNT=1, S_DONE=2) and
//    a clog2 function used for rr_ptr/owner widths.
//  - Sub-module event_counter (W-bit; sync clear, enable, active-low reset) holds cnt.
//    Clear = grant; enable = COUNT & x & ~match & req[owner].
//  - Round-robin select is combinational in the top: rotate req by rr_ptr, priority-encode,
//    then add rr_ptr back.
// TESTING
//  1 Reset: hold reset=0 for 2 cycles with req=4'b1111 -> gnt=0, done=0, cnt=0, busy=0.
//  2 Single session: req=4'b0100, target[2]=3, x=1 continuously -> gnt=4'b0100 one cycle
//    after req; cnt goes 0,1,2,3; done=4'b0100 for exactly 1 cycle; gnt=0 the cycle after.
//  3 Round-robin: req=4'b1011 held, target=0 for all -> grant order 0,1,3,0,1,3.
//    No requester is granted twice in a row while another is requesting.
//  4 Gapped x with target=2: x pattern 1,0,0,1 -> cnt 0,1,1,1,2 -> done on the next cycle.
//    An x==1 in the match cycle does not move cnt past 2.
//  5 Abort: owner 1 drops req at cnt=1 -> IDLE next edge, done stays 0, gnt=0.
//    With req[2] pending, gnt=4'b0100 on the following edge.
//  6 Mid-session reset and boundaries: reset=0 at cnt=2 -> all outputs 0 next edge, no done.
//    Separately, target=15 (W=4) with x=1 -> cnt reaches 4'hF and done fires, no wrap.

Source files
------------

// File: rtl/count_session_arbiter_pkg.sv
// count_session_arbiter_pkg
//   Shared definitions for the count session arbiter. It holds the state
//   encoding and a ceiling-log2 helper that sizes the owner and
//   round-robin pointer registers.
package count_session_arbiter_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COUNT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // Returns ceil(log2(value)). A value of 1 returns 0.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/count_session_arbiter_event_counter.sv
// event_counter
//   W-bit up counter with a synchronous clear and a count enable.
//   Clear has priority over enable.
//   Ports:
//     clk    in  1  clock
//     reset  in  1  synchronous reset, active low
//     clr_i  in  1  load zero on the next edge
//     en_i   in  1  increment on the next edge
//     cnt_o  out W  current count
module event_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/count_session_arbiter.sv
// count_session_arbiter
//   This block shares one W-bit event counter among N requesters. Grants are
//   given round-robin. A granted session counts x pulses until the count
//   equals the target that was latched at grant time. The block then pulses
//   done for the owner for one cycle.
//   Ports:
//     clk     in  1    clock
//     reset   in  1    synchronous reset, active low
//     req     in  N    level session requests
//     target  in  N*W  packed targets, requester i at target[i*W +: W]
//     x       in  1    event strobe
//     gnt     out N    registered one-hot grant
//     busy    out 1    session in progress (COUNT or DONE)
//     cnt     out W    current session count
//     done    out N    one-cycle completion pulse to the owner
module count_session_arbiter
   import count_session_arbiter_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] target,
   input  logic           x,
   output logic [N-1:0]   gnt,
   output logic           busy,
   output logic [W-1:0]   cnt,
   output logic [N-1:0]   done
);

   localparam int PW = clog2(N);

   logic [1:0]    state_q,  state_d;
   logic [N-1:0]  gnt_q,    gnt_d;
   logic [PW-1:0] owner_q,  owner_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [W-1:0]  tgt_q,    tgt_d;

   logic          grant;
   logic          match;
   logic          owner_req;
   logic          cnt_en;
   logic [PW-1:0] owner_inc;

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [PW-1:0]  rot_off;
   logic [PW:0]    sel_sum;
   logic [PW-1:0]  sel;

   // Round-robin pick. Rotate req so that rr_ptr sits at bit 0. Take the
   // lowest set bit. Then add rr_ptr back, modulo N.
   always_comb begin
      req_dbl = {req, req} >> rr_ptr_q;
      req_rot = req_dbl[N-1:0];
      rot_off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            rot_off = PW'(i);
         end
      end
      sel_sum = {1'b0, rot_off} + {1'b0, rr_ptr_q};
      if (sel_sum >= (PW+1)'(N)) begin
         sel_sum = sel_sum - (PW+1)'(N);
      end
      sel = sel_sum[PW-1:0];
   end

   assign owner_inc = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
   assign owner_req = req[owner_q];
   assign match     = (cnt == tgt_q);
   // Stop counting when a match occurs or the owner aborts. This keeps cnt
   // from moving past the target and holds cnt still on an abort.
   assign cnt_en    = (state_q == S_COUNT) & x & ~match & owner_req;

   event_counter #(.W(W)) u_event_counter (
      .clk   (clk),
      .reset (reset),
      .clr_i (grant),
      .en_i  (cnt_en),
      .cnt_o (cnt)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         gnt_q    <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         tgt_q    <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         tgt_q    <= tgt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      tgt_d    = tgt_q;
      grant    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               grant   = 1'b1;
               state_d = S_COUNT;
               gnt_d   = N'(1) << sel;
               owner_d = sel;
               tgt_d   = target[sel*W +: W];
            end
         end
         S_COUNT: begin
            if (!owner_req) begin
               state_d  = S_IDLE;
               gnt_d    = '0;
               rr_ptr_d = owner_inc;
            end else if (match) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            gnt_d    = '0;
            rr_ptr_d = owner_inc;
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      gnt  = gnt_q;
      busy = (state_q != S_IDLE);
      done = gnt_q & {N{state_q == S_DONE}};
   end

endmodule

// File: tb/tb_count_session_arbiter.sv
module tb_count_session_arbiter;

   localparam int N = 4;
   localparam int W = 4;

   logic           clk;
   logic           reset;
   logic [N-1:0]   req;
   logic [N*W-1:0] target;
   logic           x;
   logic [N-1:0]   gnt;
   logic           busy;
   logic [W-1:0]   cnt;
   logic [N-1:0]   done;

   int total = 0;
   int bad   = 0;

   // Reference model state for one session, kept in plain integers.
   bit m_active;
   bit m_fin;
   int m_owner;
   int m_tgt;
   int m_cnt;
   int m_ptr;

   count_session_arbiter #(.N(N), .W(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .target (target),
      .x      (x),
      .gnt    (gnt),
      .busy   (busy),
      .cnt    (cnt),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_step();
      bit found;
      if (!reset) begin
         m_active = 0; m_fin = 0; m_owner = 0; m_tgt = 0; m_cnt = 0; m_ptr = 0;
      end else if (!m_active) begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && req[(m_ptr + k) % N]) begin
               found    = 1;
               m_owner  = (m_ptr + k) % N;
               m_tgt    = int'(target[m_owner*W +: W]);
               m_cnt    = 0;
               m_active = 1;
               m_fin    = 0;
            end
         end
      end else if (m_fin) begin
         m_active = 0; m_fin = 0; m_ptr = (m_owner + 1) % N;
      end else if (!req[m_owner]) begin
         m_active = 0; m_ptr = (m_owner + 1) % N;
      end else if (m_cnt == m_tgt) begin
         m_fin = 1;
      end else if (x) begin
         m_cnt = m_cnt + 1;
      end
   endtask

   // Advance one clock edge with the current inputs, then settle.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; req = 4'b1111; x = 1'b1; target = '1;
      cycle();
      cycle();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
      total++; if (done !== 4'b0000) begin bad++; $display("FAIL reset_done got=%b want=0000", done); end
      total++; if (cnt !== 4'h0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      reset = 1'b1; req = '0; x = 1'b0; target = '0;
      cycle();
      $display("test_reset done");
   endtask

   task automatic test_single();
      req = 4'b0100; target = '0; target[2*W +: W] = 4'd3; x = 1'b1;
      cycle();
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b want=0100", gnt); end
      total++; if (cnt !== 4'd0) begin bad++; $display("FAIL single_cnt0 got=%0d want=0", cnt); end
      for (int c = 1; c <= 3; c++) begin
         cycle();
         total++; if (cnt !== W'(c)) begin bad++; $display("FAIL single_cnt got=%0d want=%0d", cnt, c); end
         total++; if (done !== 4'b0000) begin bad++; $display("FAIL single_early_done got=%b want=0000", done); end
      end
      cycle();
      total++; if (done !== 4'b0100) begin bad++; $display("FAIL single_done got=%b want=0100", done); end
      total++; if (cnt !== 4'd3) begin bad++; $display("FAIL single_cnt_final got=%0d want=3", cnt); end
      req = '0;
      cycle();
      total++; if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0)
         begin bad++; $display("FAIL single_release gnt=%b done=%b busy=%b want 0000/0000/0", gnt, done, busy); end
      $display("test_single done");
   endtask

   task automatic test_round_robin();
      int order [6] = '{0, 1, 3, 0, 1, 3};
      reset = 1'b0; cycle(); reset = 1'b1;
      req = 4'b1011; target = '0; x = 1'b0;
      for (int s = 0; s < 6; s++) begin
         cycle();
         total++; if (gnt !== N'(1) << order[s])
            begin bad++; $display("FAIL rr_grant session=%0d got=%b want_owner=%0d", s, gnt, order[s]); end
         cycle();
         total++; if (done !== N'(1) << order[s])
            begin bad++; $display("FAIL rr_done session=%0d got=%b want_owner=%0d", s, done, order[s]); end
         cycle();
         total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_idle session=%0d got=%b want=0000", s, gnt); end
      end
      req = '0;
      $display("test_round_robin done");
   endtask

   task automatic test_gapped();
      bit xs  [4] = '{1, 0, 0, 1};
      int exp [4] = '{1, 1, 1, 2};
      req = 4'b0001; target = '0; target[0 +: W] = 4'd2; x = 1'b0;
      cycle();
      total++; if (gnt !== 4'b0001 || cnt !== 4'd0)
         begin bad++; $display("FAIL gap_grant gnt=%b cnt=%0d want 0001/0", gnt, cnt); end
      for (int i = 0; i < 4; i++) begin
         x = xs[i];
         cycle();
         total++; if (cnt !== W'(exp[i]) || done !== 4'b0000)
            begin bad++; $display("FAIL gap_cnt step=%0d cnt=%0d done=%b want %0d/0000", i, cnt, done, exp[i]); end
      end
      x = 1'b1;
      cycle();
      total++; if (done !== 4'b0001 || cnt !== 4'd2)
         begin bad++; $display("FAIL gap_done done=%b cnt=%0d want 0001/2", done, cnt); end
      req = '0; x = 1'b0;
      cycle();
      total++; if (gnt !== 4'b0000 || cnt !== 4'd2)
         begin bad++; $display("FAIL gap_hold gnt=%b cnt=%0d want 0000/2", gnt, cnt); end
      $display("test_gapped done");
   endtask

   task automatic test_abort();
      req = 4'b0110; target = '0; target[1*W +: W] = 4'd5; target[2*W +: W] = 4'd1; x = 1'b1;
      cycle();
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL abort_grant got=%b want=0010", gnt); end
      cycle();
      total++; if (cnt !== 4'd1) begin bad++; $display("FAIL abort_cnt got=%0d want=1", cnt); end
      req = 4'b0100;
      cycle();
      total++; if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || cnt !== 4'd1)
         begin bad++; $display("FAIL abort_idle gnt=%b done=%b busy=%b cnt=%0d want 0000/0000/0/1", gnt, done, busy, cnt); end
      cycle();
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL abort_next got=%b want=0100", gnt); end
      req = '0;
      cycle();
      $display("test_abort done");
   endtask

   task automatic test_midreset_and_max();
      req = 4'b0001; target = '0; target[0 +: W] = 4'd5; x = 1'b1;
      cycle(); cycle(); cycle();
      total++; if (cnt !== 4'd2) begin bad++; $display("FAIL midrst_pre got=%0d want=2", cnt); end
      reset = 1'b0;
      cycle();
      total++; if (gnt !== 4'b0000 || done !== 4'b0000 || cnt !== 4'd0 || busy !== 1'b0)
         begin bad++; $display("FAIL midrst gnt=%b done=%b cnt=%0d busy=%b want all 0", gnt, done, cnt, busy); end
      reset = 1'b1; req = 4'b1000; target[3*W +: W] = 4'hF;
      cycle();
      total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL max_grant got=%b want=1000", gnt); end
      for (int i = 0; i < 15; i++) cycle();
      total++; if (cnt !== 4'hF || done !== 4'b0000)
         begin bad++; $display("FAIL max_cnt cnt=%0d done=%b want 15/0000", cnt, done); end
      cycle();
      total++; if (done !== 4'b1000 || cnt !== 4'hF)
         begin bad++; $display("FAIL max_done done=%b cnt=%0d want 1000/15", done, cnt); end
      req = '0;
      cycle();
      $display("test_midreset_and_max done");
   endtask

   task automatic test_random();
      logic [N-1:0] e_gnt;
      logic [N-1:0] e_done;
      for (int t = 0; t < 800; t++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            target[i*W +: W] = W'($urandom_range(0, 6));
         end
         x     = ($urandom_range(0, 2) != 0);
         reset = ($urandom_range(0, 149) != 0);
         cycle();
         e_gnt  = m_active ? (N'(1) << m_owner) : '0;
         e_done = (m_active && m_fin) ? (N'(1) << m_owner) : '0;
         total++; if (gnt !== e_gnt)
            begin bad++; $display("FAIL rand_gnt t=%0d got=%b want=%b", t, gnt, e_gnt); end
         total++; if (done !== e_done)
            begin bad++; $display("FAIL rand_done t=%0d got=%b want=%b", t, done, e_done); end
         total++; if (cnt !== W'(m_cnt))
            begin bad++; $display("FAIL rand_cnt t=%0d got=%0d want=%0d", t, cnt, m_cnt); end
         total++; if (busy !== m_active)
            begin bad++; $display("FAIL rand_busy t=%0d got=%b want=%b", t, busy, m_active); end
      end
      reset = 1'b1;
      $display("test_random done");
   endtask

   initial begin
      reset = 1'b0; req = '0; target = '0; x = 1'b0;
      m_active = 0; m_fin = 0; m_owner = 0; m_tgt = 0; m_cnt = 0; m_ptr = 0;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_gapped();
      test_abort();
      test_midreset_and_max();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
